// File: rtl/stopwatch_pkg.sv
// Shared state encoding and default timing constants for the stopwatch control path.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    localparam int DEF_TICK_DIV        = 10000000;
    localparam int DEF_FAST_MULT       = 5;
    localparam int DEF_FLASH_DIV       = 25000000;
    localparam int DEF_DEBOUNCE_CYCLES = 1000000;

endpackage

// File: rtl/stopwatch_sequencer_if.sv
// Control bundle between the sequencer and the BCD counter / display driver.
interface stopwatch_sequencer_if;

    logic cnt_en;
    logic cnt_up;
    logic cnt_clr;
    logic cnt_zero;
    logic lap_hold;
    logic blank;

    modport master (
        output cnt_en, cnt_up, cnt_clr, lap_hold, blank,
        input  cnt_zero
    );

    modport slave (
        input  cnt_en, cnt_up, cnt_clr, lap_hold, blank,
        output cnt_zero
    );

endinterface

// File: rtl/stopwatch_sequencer_btn_conditioner.sv
// Push-button conditioner: 2-flop synchronizer, optional debounce, rising-edge pulse.
// Debounce is compiled in only when STOPWATCH_DEBOUNCE_EN is defined.
module btn_conditioner
`ifdef STOPWATCH_DEBOUNCE_EN
#(
    parameter int DEBOUNCE_CYCLES = stopwatch_pkg::DEF_DEBOUNCE_CYCLES
)
`endif
(
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    logic sync0;
    logic sync1;
    logic level;
    logic level_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
        end else begin
            sync0 <= btn;
            sync1 <= sync0;
        end
    end

`ifdef STOPWATCH_DEBOUNCE_EN
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [DW-1:0] stable_cnt;

    // The level only follows the synchronizer after it has disagreed for a full window.
    always_ff @(posedge clk) begin
        if (reset) begin
            level      <= 1'b0;
            stable_cnt <= '0;
        end else if (sync1 == level) begin
            stable_cnt <= '0;
        end else if (stable_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
            level      <= sync1;
            stable_cnt <= '0;
        end else begin
            stable_cnt <= stable_cnt + 1'b1;
        end
    end
`else
    assign level = sync1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            level_d <= 1'b0;
        end else begin
            level_d <= level;
        end
    end

    assign pulse = level & ~level_d;

endmodule

// File: rtl/stopwatch_sequencer.sv
// Control FSM for the 4-digit BCD stopwatch/timer: button commands to count/clear/lap/blank.
// Define STOPWATCH_DEBOUNCE_EN to add per-button debouncing in front of edge detection.
module stopwatch_sequencer
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV  = DEF_TICK_DIV,
    parameter int FAST_MULT = DEF_FAST_MULT,
    parameter int FLASH_DIV = DEF_FLASH_DIV
`ifdef STOPWATCH_DEBOUNCE_EN
    ,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  btn_start,
    input  logic                  btn_stop,
    input  logic                  btn_lap,
    input  logic                  btn_clear,
    input  logic                  sw_up,
    input  logic                  sw_set,
    stopwatch_sequencer_if.master ctrl,
    output logic [1:0]            state
);

    localparam int PW = $clog2(TICK_DIV + FAST_MULT + 1);
    localparam int FW = $clog2(FLASH_DIV + 1);

    logic [3:0] raw_btn;
    logic [3:0] cmd;
    logic       start_p;
    logic       stop_p;
    logic       lap_p;
    logic       clear_p;

    assign raw_btn = {btn_clear, btn_lap, btn_stop, btn_start};
    assign start_p = cmd[0];
    assign stop_p  = cmd[1];
    assign lap_p   = cmd[2];
    assign clear_p = cmd[3];

`ifdef STOPWATCH_DEBOUNCE_EN
    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn [3:0] (
        .clk(clk), .reset(reset), .btn(raw_btn), .pulse(cmd)
    );
`else
    btn_conditioner u_btn [3:0] (
        .clk(clk), .reset(reset), .btn(raw_btn), .pulse(cmd)
    );
`endif

    state_t        state_r;
    logic          cnt_en_r;
    logic          cnt_clr_r;
    logic          lap_hold_r;
    logic          blank_r;
    logic          cnt_up_r;
    logic          set_mode;
    logic [PW-1:0] prescaler;
    logic [PW-1:0] pre_sum;
    logic          terminal;
    logic [FW-1:0] flash_cnt;

    // Terminal is the last prescaler step of a period: with unit steps that is
    // prescaler == TICK_DIV-1, and in set mode the step that would pass it.
    always_comb begin
        pre_sum  = prescaler + (set_mode ? PW'(FAST_MULT) : PW'(1));
        terminal = (pre_sum >= PW'(TICK_DIV));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            cnt_en_r   <= 1'b0;
            cnt_clr_r  <= 1'b0;
            lap_hold_r <= 1'b0;
            blank_r    <= 1'b0;
            cnt_up_r   <= 1'b1;
            set_mode   <= 1'b0;
            prescaler  <= '0;
            flash_cnt  <= '0;
        end else begin
            cnt_en_r  <= 1'b0;
            cnt_clr_r <= 1'b0;
            if (state_r != ST_RUN) begin
                cnt_up_r <= sw_up;
                set_mode <= sw_set;
            end
            case (state_r)
                ST_IDLE: begin
                    lap_hold_r <= 1'b0;
                    blank_r    <= 1'b0;
                    if (clear_p) begin
                        cnt_clr_r <= 1'b1;
                    end else if (start_p) begin
                        state_r   <= ST_RUN;
                        prescaler <= '0;
                    end
                end
                ST_RUN: begin
                    // A stop wins over a coincident terminal step, so no count is issued.
                    if (stop_p) begin
                        state_r <= ST_PAUSE;
                    end else begin
                        if (lap_p) begin
                            lap_hold_r <= ~lap_hold_r;
                        end
                        if (terminal) begin
                            prescaler <= '0;
                            if (!cnt_up_r && ctrl.cnt_zero && !set_mode) begin
                                state_r   <= ST_EXPIRED;
                                blank_r   <= 1'b1;
                                flash_cnt <= '0;
                            end else begin
                                cnt_en_r <= 1'b1;
                            end
                        end else begin
                            prescaler <= pre_sum;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (clear_p) begin
                        cnt_clr_r  <= 1'b1;
                        lap_hold_r <= 1'b0;
                        state_r    <= ST_IDLE;
                    end else if (start_p) begin
                        state_r   <= ST_RUN;
                        prescaler <= '0;
                    end else if (lap_p) begin
                        lap_hold_r <= ~lap_hold_r;
                    end
                end
                ST_EXPIRED: begin
                    if (clear_p || stop_p) begin
                        cnt_clr_r  <= clear_p;
                        blank_r    <= 1'b0;
                        lap_hold_r <= 1'b0;
                        state_r    <= ST_IDLE;
                    end else if (flash_cnt == FW'(FLASH_DIV - 1)) begin
                        flash_cnt <= '0;
                        blank_r   <= ~blank_r;
                    end else begin
                        flash_cnt <= flash_cnt + 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign ctrl.cnt_en   = cnt_en_r;
    assign ctrl.cnt_up   = cnt_up_r;
    assign ctrl.cnt_clr  = cnt_clr_r;
    assign ctrl.lap_hold = lap_hold_r;
    assign ctrl.blank    = blank_r;
    assign state         = state_r;

endmodule

// File: tb/tb_stopwatch_sequencer.sv
// Directed, table-driven bench for stopwatch_sequencer with short divider settings.
module tb_stopwatch_sequencer;

    localparam int TICK_DIV  = 10;
    localparam int FAST_MULT = 5;
    localparam int FLASH_DIV = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_start;
    logic       btn_stop;
    logic       btn_lap;
    logic       btn_clear;
    logic       sw_up;
    logic       sw_set;
    logic [1:0] state;

    stopwatch_sequencer_if bus ();

    stopwatch_sequencer #(
        .TICK_DIV (TICK_DIV),
        .FAST_MULT(FAST_MULT),
        .FLASH_DIV(FLASH_DIV)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_start(btn_start),
        .btn_stop (btn_stop),
        .btn_lap  (btn_lap),
        .btn_clear(btn_clear),
        .sw_up    (sw_up),
        .sw_set   (sw_set),
        .ctrl     (bus),
        .state    (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        bit    start;
        bit    stop;
        bit    lap;
        bit    clr;
        bit    up;
        bit    set;
        bit    zero;
        int    cycles;
        int    exp_state;
        int    exp_en;
        int    exp_clr;
        int    exp_lap;
        int    exp_blank;
        int    exp_up;
    } vec_t;

    vec_t vecs[$];
    int   n_compared = 0;
    int   n_failed   = 0;

    task automatic check_output(input string name, input int actual, input int expected);
        n_compared++;
        if (actual != expected) begin
            n_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic add(input string name, input bit start, input bit stop, input bit lap,
                       input bit clr, input bit up, input bit set, input bit zero,
                       input int cycles, input int st, input int en, input int clr_n,
                       input int lap_h, input int blank, input int cnt_up);
        vec_t v;
        v.name = name;      v.start = start;   v.stop = stop;     v.lap = lap;
        v.clr = clr;        v.up = up;         v.set = set;       v.zero = zero;
        v.cycles = cycles;  v.exp_state = st;  v.exp_en = en;     v.exp_clr = clr_n;
        v.exp_lap = lap_h;  v.exp_blank = blank; v.exp_up = cnt_up;
        vecs.push_back(v);
    endtask

    // Hold the inputs for v.cycles clocks, count pulses, then check the settled outputs.
    task automatic apply_stimulus(input vec_t v);
        int en_n   = 0;
        int clr_n  = 0;
        int both_n = 0;
        btn_start    = v.start;
        btn_stop     = v.stop;
        btn_lap      = v.lap;
        btn_clear    = v.clr;
        sw_up        = v.up;
        sw_set       = v.set;
        bus.cnt_zero = v.zero;
        repeat (v.cycles) begin
            @(posedge clk);
            #1;
            if (bus.cnt_en)  en_n++;
            if (bus.cnt_clr) clr_n++;
            if (bus.cnt_en && bus.cnt_clr) both_n++;
        end
        check_output({v.name, ".state"},    int'(state),        v.exp_state);
        check_output({v.name, ".en_count"}, en_n,               v.exp_en);
        check_output({v.name, ".clr_count"}, clr_n,             v.exp_clr);
        check_output({v.name, ".lap_hold"}, int'(bus.lap_hold), v.exp_lap);
        check_output({v.name, ".blank"},    int'(bus.blank),    v.exp_blank);
        check_output({v.name, ".cnt_up"},   int'(bus.cnt_up),   v.exp_up);
        check_output({v.name, ".en_clr_overlap"}, both_n, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t v;

        //   name            st sp lp cl up se ze cyc  st en cl lap bl up
        add("idle_down_sw",  0, 0, 0, 0, 0, 0, 0, 2,   0, 0, 0, 0, 0, 0);
        add("idle_up_sw",    0, 0, 0, 0, 1, 0, 0, 2,   0, 0, 0, 0, 0, 1);
        add("start_wait",    1, 0, 0, 0, 1, 0, 0, 2,   0, 0, 0, 0, 0, 1);
        add("start_act",     1, 0, 0, 0, 1, 0, 0, 1,   1, 0, 0, 0, 0, 1);
        add("run_first9",    0, 0, 0, 0, 1, 0, 0, 9,   1, 0, 0, 0, 0, 1);
        add("run_step1",     0, 0, 0, 0, 1, 0, 0, 1,   1, 1, 0, 0, 0, 1);
        add("run_20cyc",     0, 0, 0, 0, 1, 0, 0, 20,  1, 2, 0, 0, 0, 1);
        add("stop_press",    0, 1, 0, 0, 1, 0, 0, 3,   2, 0, 0, 0, 0, 1);
        add("pause_hold",    0, 0, 0, 0, 1, 0, 0, 15,  2, 0, 0, 0, 0, 1);
        add("resume",        1, 0, 0, 0, 1, 0, 0, 3,   1, 0, 0, 0, 0, 1);
        add("resume_rel",    0, 0, 0, 0, 1, 0, 0, 4,   1, 0, 0, 0, 0, 1);
        add("stop_start",    1, 1, 0, 0, 1, 0, 0, 3,   2, 0, 0, 0, 0, 1);
        add("pause_rel",     0, 0, 0, 0, 1, 0, 0, 4,   2, 0, 0, 0, 0, 1);
        add("clr_start",     1, 0, 0, 1, 1, 0, 0, 3,   0, 0, 1, 0, 0, 1);
        add("clr_rel",       0, 0, 0, 0, 1, 0, 0, 4,   0, 0, 0, 0, 0, 1);
        add("lap_run",       1, 0, 0, 0, 1, 0, 0, 3,   1, 0, 0, 0, 0, 1);
        add("lap_run_rel",   0, 0, 0, 0, 1, 0, 0, 3,   1, 0, 0, 0, 0, 1);
        add("lap_on",        0, 0, 1, 0, 1, 0, 0, 3,   1, 0, 0, 1, 0, 1);
        add("lap_on_rel",    0, 0, 0, 0, 1, 0, 0, 3,   1, 0, 0, 1, 0, 1);
        add("lap_off",       0, 0, 1, 0, 1, 0, 0, 3,   1, 1, 0, 0, 0, 1);
        add("lap_off_rel",   0, 0, 0, 0, 1, 0, 0, 3,   1, 0, 0, 0, 0, 1);
        add("lap_on2",       0, 0, 1, 0, 1, 0, 0, 3,   1, 0, 0, 1, 0, 1);
        add("lap_on2_rel",   0, 0, 0, 0, 1, 0, 0, 3,   1, 1, 0, 1, 0, 1);
        add("lap_stop",      0, 1, 0, 0, 1, 0, 0, 3,   2, 0, 0, 1, 0, 1);
        add("lap_stop_rel",  0, 0, 0, 0, 1, 0, 0, 3,   2, 0, 0, 1, 0, 1);
        add("lap_resume",    1, 0, 0, 0, 1, 0, 0, 3,   1, 0, 0, 1, 0, 1);
        add("lap_res_rel",   0, 0, 0, 0, 1, 0, 0, 3,   1, 0, 0, 1, 0, 1);
        add("lap_stop2",     0, 1, 0, 0, 1, 0, 0, 3,   2, 0, 0, 1, 0, 1);
        add("lap_stop2_rel", 0, 0, 0, 0, 1, 0, 0, 3,   2, 0, 0, 1, 0, 1);
        add("lap_clear",     0, 0, 0, 1, 1, 0, 0, 3,   0, 0, 1, 0, 0, 1);
        add("lap_clr_rel",   0, 0, 0, 0, 1, 0, 0, 3,   0, 0, 0, 0, 0, 1);
        add("exp_down_sw",   0, 0, 0, 0, 0, 0, 0, 2,   0, 0, 0, 0, 0, 0);
        add("exp_start",     1, 0, 0, 0, 0, 0, 0, 3,   1, 0, 0, 0, 0, 0);
        add("exp_run9",      0, 0, 0, 0, 1, 0, 1, 9,   1, 0, 0, 0, 0, 0);
        add("exp_enter",     0, 0, 0, 0, 1, 0, 1, 1,   3, 0, 0, 0, 1, 0);
        add("exp_blank_a",   0, 0, 0, 0, 1, 0, 1, 3,   3, 0, 0, 0, 1, 1);
        add("exp_blank_b",   0, 0, 0, 0, 1, 0, 1, 1,   3, 0, 0, 0, 0, 1);
        add("exp_blank_c",   0, 0, 0, 0, 1, 0, 1, 4,   3, 0, 0, 0, 1, 1);
        add("exp_blank_d",   0, 0, 0, 0, 1, 0, 1, 3,   3, 0, 0, 0, 1, 1);
        add("exp_ign_cmd",   1, 0, 1, 0, 1, 0, 1, 4,   3, 0, 0, 0, 0, 1);
        add("exp_blank_e",   0, 0, 0, 0, 1, 0, 1, 1,   3, 0, 0, 0, 1, 1);
        add("exp_stop",      0, 1, 0, 0, 1, 0, 1, 3,   0, 0, 0, 0, 0, 1);
        add("exp_stop_rel",  0, 0, 0, 0, 1, 0, 0, 4,   0, 0, 0, 0, 0, 1);
        add("set_idle",      0, 0, 0, 0, 0, 1, 1, 2,   0, 0, 0, 0, 0, 0);
        add("set_start",     1, 0, 0, 0, 0, 1, 1, 3,   1, 0, 0, 0, 0, 0);
        add("set_run21",     0, 0, 0, 0, 0, 1, 1, 21,  1, 10, 0, 0, 0, 0);
        add("set_stop_tc",   0, 1, 0, 0, 0, 1, 1, 3,   2, 1, 0, 0, 0, 0);
        add("set_pause",     0, 0, 0, 0, 1, 0, 0, 3,   2, 0, 0, 0, 0, 1);
        add("set_clear",     0, 0, 0, 1, 1, 0, 0, 3,   0, 0, 1, 0, 0, 1);
        add("set_clr_rel",   0, 0, 0, 0, 1, 0, 0, 3,   0, 0, 0, 0, 0, 1);
        add("hold_start",    1, 0, 0, 0, 1, 0, 0, 50,  1, 4, 0, 0, 0, 1);
        add("hold_lap",      0, 0, 1, 0, 1, 0, 0, 20,  1, 2, 0, 1, 0, 1);

        reset        = 1'b1;
        btn_start    = 1'b0;
        btn_stop     = 1'b0;
        btn_lap      = 1'b0;
        btn_clear    = 1'b0;
        sw_up        = 1'b0;
        sw_set       = 1'b0;
        bus.cnt_zero = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset.state",    int'(state),        0);
        check_output("reset.cnt_up",   int'(bus.cnt_up),   1);
        check_output("reset.cnt_en",   int'(bus.cnt_en),   0);
        check_output("reset.cnt_clr",  int'(bus.cnt_clr),  0);
        check_output("reset.lap_hold", int'(bus.lap_hold), 0);
        check_output("reset.blank",    int'(bus.blank),    0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i]);
        end

        // Reset while running with lap_hold set and the direction switch down.
        btn_lap = 1'b0;
        sw_up   = 1'b0;
        reset   = 1'b1;
        @(posedge clk);
        #1;
        check_output("mid_reset.state",    int'(state),        0);
        check_output("mid_reset.cnt_up",   int'(bus.cnt_up),   1);
        check_output("mid_reset.cnt_en",   int'(bus.cnt_en),   0);
        check_output("mid_reset.cnt_clr",  int'(bus.cnt_clr),  0);
        check_output("mid_reset.lap_hold", int'(bus.lap_hold), 0);
        check_output("mid_reset.blank",    int'(bus.blank),    0);
        reset = 1'b0;

        v.name = "post_reset";  v.start = 0;  v.stop = 0;  v.lap = 0;  v.clr = 0;
        v.up = 0;  v.set = 0;  v.zero = 0;  v.cycles = 12;  v.exp_state = 0;
        v.exp_en = 0;  v.exp_clr = 0;  v.exp_lap = 0;  v.exp_blank = 0;  v.exp_up = 0;
        apply_stimulus(v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule

// File: doc/stopwatch_sequencer.md
Name: stopwatch_sequencer

Overview:
Central control FSM for the 4-digit BCD stopwatch/timer datapath. It conditions the push-buttons and produces the count-enable pulses, count direction, clear, lap-freeze and display-blank controls for the BCD up/down counter and the four-digit display driver. It sits between board I/O and the counter/display, and replaces ad-hoc level-sensitive control with explicit states and edge-triggered commands.

Parameters:
TICK_DIV, 10000000, clk cycles per count step in normal mode (10 Hz at 100 MHz)
FAST_MULT, 5, prescaler increment per cycle in set mode (steps FAST_MULT times faster)
FLASH_DIV, 25000000, clk cycles between blank toggles in EXPIRED
DEBOUNCE_CYCLES, 1000000, stable-level cycles required per button (DEBOUNCE_EN only)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
btn_start  in  1  raw start button
btn_stop  in  1  raw stop button
btn_lap  in  1  raw lap button
btn_clear  in  1  raw clear button
sw_up  in  1  direction switch: 1 up, 0 down
sw_set  in  1  set-mode switch: fast count, no expiry
cnt_zero  in  1  counter reports 0000
cnt_en  out  1  one-cycle count-step pulse
cnt_up  out  1  count direction to counter
cnt_clr  out  1  one-cycle synchronous clear to counter
lap_hold  out  1  display freezes latched value while high
blank  out  1  display blank (flash) control
state  out  2  current FSM state, for debug LEDs

Behaviour:
- Reset (clk, reset synchronous active-high): state=IDLE, cnt_en=0, cnt_clr=0, lap_hold=0, blank=0, cnt_up=1, set_mode=0, prescaler=0, flash counter=0.
- Buttons: each goes through a 2-flop synchronizer and rising-edge detect. Commands are 1-cycle edges; a held button fires once.
- States: IDLE=0, RUN=1, PAUSE=2, EXPIRED=3.
- cnt_up and set_mode follow sw_up/sw_set every cycle when state!=RUN. They are frozen in RUN.
- Simultaneous edges, priority: clear > stop > start > lap. At most one command acts per cycle.
- IDLE: start -> RUN. clear -> cnt_clr pulse, stay IDLE.
- RUN: stop -> PAUSE. lap -> toggle lap_hold. clear ignored.
- PAUSE: start -> RUN. clear -> cnt_clr pulse, lap_hold=0, -> IDLE. lap -> toggle lap_hold.
- EXPIRED: stop or clear -> blank=0, -> IDLE (clear also pulses cnt_clr). start and lap ignored.
- Prescaler runs only in RUN:
  - It adds 1 per cycle, or FAST_MULT when set_mode=1.
  - When it reaches >= TICK_DIV-1 (terminal) it restarts at 0.
  - It is zeroed on every entry to RUN, so the first step is a full period after start.
- At terminal:
  - If cnt_up=0, cnt_zero=1 and set_mode=0: no cnt_en, -> EXPIRED.
  - Otherwise: cnt_en=1 for exactly that cycle.
- A stop edge in the same cycle as terminal takes priority: no cnt_en is issued, -> PAUSE.
- Up-count wrap 9999->0000 is the counter's job and does not expire.
- Entering IDLE always forces lap_hold=0.
- Entering RUN from PAUSE keeps lap_hold.
- EXPIRED: blank toggles every FLASH_DIV cycles, starting at 1 on entry. blank=0 in all other states.
- cnt_clr and cnt_en are never high in the same cycle.
- Reset mid-RUN: immediate IDLE. No cnt_clr pulse; the counter has its own reset.

Optional Feature:
STOPWATCH_DEBOUNCE_EN: when defined, each synchronized button must stay stable for DEBOUNCE_CYCLES before its level updates. The edge is detected on the debounced level, so command latency is about DEBOUNCE_CYCLES+3. Without it, edges come straight from the synchronizer (latency 3 cycles from pin to action) and bouncing can issue repeated commands.

Decomposition:
- Package stopwatch_pkg: 2-bit state encoding constants (ST_IDLE, ST_RUN, ST_PAUSE, ST_EXPIRED) and default divider constants shared with the top level.
- Sub-module btn_conditioner: synchronizer, optional debounce and rising-edge pulse. Instantiated four times.

Test Plan:
All tests use TICK_DIV=10, FAST_MULT=5, FLASH_DIV=4.
- Start in IDLE, up, set off -> RUN within 3 cycles; cnt_en pulses every 10 cycles; stop -> PAUSE, no further cnt_en.
- Down count, cnt_zero forced 1 in RUN -> at first terminal no cnt_en, state=3, blank toggles every 4 cycles; stop -> IDLE, blank=0.
- sw_set=1 in IDLE, then start -> cnt_en every 2 cycles; cnt_zero=1 with down count -> stays RUN, never EXPIRED.
- Stop and start edges in the same cycle in RUN -> PAUSE. Clear and start together in PAUSE -> cnt_clr pulse, IDLE.
- Lap in RUN -> lap_hold=1; lap again -> 0; lap, stop, clear -> lap_hold=0 on entering IDLE.
- Hold btn_start high for 50 cycles from IDLE -> a single transition and no re-trigger. Assert reset mid-RUN -> state=0, cnt_up=1, all pulses 0 next cycle.
